// File: rtl/alu_issue_seq.sv
// Multi-cycle issue sequencer: accepts one instruction per handshake and steps
// IDLE->DECODE->EXEC->WB, driving registered ALU/register-file controls. Optional macro: ALU_SEQ_PIPE_EN.
module alu_issue_seq #(
    parameter bit          IMM_SIGNED = 1'b1,
    parameter logic [3:0]  CMP_EXT    = 4'hB,
    parameter logic [15:0] NOP_WORD   = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [7:0]  alu_op,
    output logic [4:0]  muxA,
    output logic [4:0]  muxB,
    output logic [15:0] imm,
    output logic        imm_control,
    output logic [15:0] regs_en,
    output logic        buff_en,
    output logic        flag_en,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t      state_reg, state_next;
    logic [15:0] instr_reg, instr_next;
    logic        accept;

    logic [3:0]  op_hi, rdest, op_ext, rsrc;
    logic        reg_form, is_cmp, is_nop, ctrl_on;
    logic [15:0] imm_ext, onehot;

    logic        ready_next, busy_next, done_next, immc_next, buff_next, flag_next;
    logic [7:0]  alu_next;
    logic [4:0]  mux_a_next, mux_b_next;
    logic [15:0] imm_next, regs_next;

    assign accept = instr_valid & instr_ready;

    always_comb begin
        state_next = state_reg;
        instr_next = instr_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = DECODE;
                    instr_next = instr;
                end
            end
            DECODE: state_next = EXEC;
            EXEC:   state_next = WB;
            WB: begin
`ifdef ALU_SEQ_PIPE_EN
                if (accept) begin
                    state_next = DECODE;
                    instr_next = instr;
                end else begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Decode the instruction that will be current next cycle, so every output can be registered.
    assign op_hi    = instr_next[15:12];
    assign rdest    = instr_next[11:8];
    assign op_ext   = instr_next[7:4];
    assign rsrc     = instr_next[3:0];
    assign reg_form = (op_hi == 4'h0);
    assign is_cmp   = reg_form ? (op_ext == CMP_EXT) : (op_hi == CMP_EXT);
    assign is_nop   = (instr_next == NOP_WORD);
    assign imm_ext  = IMM_SIGNED ? {{8{instr_next[7]}}, instr_next[7:0]} : {8'h00, instr_next[7:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_onehot
            assign onehot[gi] = (rdest == 4'(gi));
        end
    endgenerate

    always_comb begin
        ctrl_on    = (state_next != IDLE);
`ifdef ALU_SEQ_PIPE_EN
        ready_next = (state_next == IDLE) || (state_next == WB);
`else
        ready_next = (state_next == IDLE);
`endif
        busy_next  = ctrl_on;
        alu_next   = 8'h00;
        mux_a_next = 5'd0;
        mux_b_next = 5'd0;
        imm_next   = 16'h0000;
        immc_next  = 1'b0;
        if (ctrl_on) begin
            alu_next   = reg_form ? {4'h0, op_ext} : {op_hi, 4'h0};
            mux_a_next = {1'b0, rdest};
            mux_b_next = {1'b0, rsrc};
            imm_next   = reg_form ? 16'h0000 : imm_ext;
            immc_next  = ~reg_form;
        end
        buff_next = ((state_next == EXEC) || (state_next == WB)) && !is_nop;
        flag_next = (state_next == WB) && !is_nop;
        done_next = (state_next == WB);
        regs_next = ((state_next == WB) && !is_nop && !is_cmp) ? onehot : 16'h0000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            instr_reg   <= 16'h0000;
            instr_ready <= 1'b0;
            alu_op      <= 8'h00;
            muxA        <= 5'd0;
            muxB        <= 5'd0;
            imm         <= 16'h0000;
            imm_control <= 1'b0;
            regs_en     <= 16'h0000;
            buff_en     <= 1'b0;
            flag_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_reg   <= state_next;
            instr_reg   <= instr_next;
            instr_ready <= ready_next;
            alu_op      <= alu_next;
            muxA        <= mux_a_next;
            muxB        <= mux_b_next;
            imm         <= imm_next;
            imm_control <= immc_next;
            regs_en     <= regs_next;
            buff_en     <= buff_next;
            flag_en     <= flag_next;
            busy        <= busy_next;
            done        <= done_next;
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: directed vector table, reset abort,
// handshake throughput and randomized instructions against a phase-level reference model.
module tb_alu_issue_seq;

`ifdef ALU_SEQ_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif
    localparam bit IMM_SIGNED = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [7:0]  alu_op;
    logic [4:0]  muxA, muxB;
    logic [15:0] imm;
    logic        imm_control;
    logic [15:0] regs_en;
    logic        buff_en, flag_en, busy, done;

    alu_issue_seq #(.IMM_SIGNED(IMM_SIGNED), .CMP_EXT(4'hB), .NOP_WORD(16'h0000)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_op(alu_op), .muxA(muxA), .muxB(muxB),
        .imm(imm), .imm_control(imm_control), .regs_en(regs_en), .buff_en(buff_en),
        .flag_en(flag_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic [7:0]  alu;
        logic [4:0]  ma;
        logic [4:0]  mb;
        logic [15:0] imm;
        logic        immc;
        logic [15:0] regs;
        logic        buff;
        logic        flag;
        logic        busy;
        logic        done;
    } outs_t;

    typedef struct {
        logic [15:0] w;
        logic [7:0]  alu;
        logic [15:0] imm;
        logic        immc;
        logic [15:0] regs_wb;
        logic        flag_wb;
    } vec_t;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    function automatic outs_t snap();
        outs_t s;
        s = '{instr_ready, alu_op, muxA, muxB, imm, imm_control, regs_en, buff_en, flag_en, busy, done};
        return s;
    endfunction

    // Expected outputs during phase ph (0 idle, 1 decode, 2 exec, 3 writeback) for word w.
    function automatic outs_t model(input logic [15:0] w, input int ph);
        outs_t e;
        int    v;
        bit    reg_form, nop, cmp;
        e = '0;
        e.ready = (ph == 0) || (PIPE && ph == 3);
        if (ph == 0) return e;
        reg_form = (w[15:12] == 4'h0);
        nop      = (w == 16'h0000);
        cmp      = reg_form ? (w[7:4] == 4'hB) : (w[15:12] == 4'hB);
        e.busy = 1'b1;
        e.ma   = {1'b0, w[11:8]};
        e.mb   = {1'b0, w[3:0]};
        if (reg_form) begin
            e.alu = {4'h0, w[7:4]};
        end else begin
            e.alu  = {w[15:12], 4'h0};
            e.immc = 1'b1;
            v = int'(w[7:0]);
            if (IMM_SIGNED && v > 127) v = v - 256;
            e.imm = v[15:0];
        end
        e.buff = (ph >= 2) && !nop;
        e.flag = (ph == 3) && !nop;
        e.done = (ph == 3);
        if (ph == 3 && !nop && !cmp) e.regs = 16'd1 << w[11:8];
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("ready_timeout", 64'(instr_ready), 64'd1);
    endtask

    // Called at a negedge: present w, let it be accepted, then scramble the inputs.
    task automatic issue(input logic [15:0] w);
        wait_ready();
        instr_valid = 1'b1;
        instr = w;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 16'($urandom);
    endtask

    task automatic run_model(input logic [15:0] w);
        issue(w);
        for (int ph = 1; ph <= 4; ph++) begin
            @(negedge clk);
            chk($sformatf("w%h_ph%0d", w, ph % 4), 64'(snap()), 64'(model(w, ph % 4)));
        end
    endtask

    vec_t vecs[7];
    int   done_cyc[$];
    int   idx;
    logic [15:0] q[3];
    logic [15:0] w;

    initial begin
        vecs[0] = '{16'h0352, 8'h05, 16'h0000, 1'b0, 16'h0008, 1'b1};
        vecs[1] = '{16'h51F6, 8'h50, 16'hFFF6, 1'b1, 16'h0002, 1'b1};
        vecs[2] = '{16'h04B7, 8'h0B, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{16'h0000, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'hB123, 8'hB0, 16'h0023, 1'b1, 16'h0000, 1'b1};
        vecs[5] = '{16'h0FA9, 8'h0A, 16'h0000, 1'b0, 16'h8000, 1'b1};
        vecs[6] = '{16'h7F80, 8'h70, 16'hFF80, 1'b1, 16'h8000, 1'b1};

        reset = 1'b0;
        instr_valid = 1'b0;
        instr = 16'h0000;
        @(negedge clk);
        chk("reset_state", 64'(snap()), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_after_release", 64'(snap()), 64'(model(16'h0, 0)));

        // Directed table
        foreach (vecs[i]) begin
            issue(vecs[i].w);
            @(negedge clk);
            chk($sformatf("v%0d_dec_alu", i), 64'(alu_op), 64'(vecs[i].alu));
            chk($sformatf("v%0d_dec_imm", i), 64'({imm_control, imm}), 64'({vecs[i].immc, vecs[i].imm}));
            chk($sformatf("v%0d_dec_en", i), 64'({regs_en, buff_en, flag_en}), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_exec_buff", i), 64'(buff_en), 64'(vecs[i].w != 16'h0));
            @(negedge clk);
            chk($sformatf("v%0d_wb_regs", i), 64'(regs_en), 64'(vecs[i].regs_wb));
            chk($sformatf("v%0d_wb_flag_done", i), 64'({flag_en, done}), 64'({vecs[i].flag_wb, 1'b1}));
            @(negedge clk);
            chk($sformatf("v%0d_idle", i), 64'(snap()), 64'(model(16'h0, 0)));
        end

        // Reset in the middle of EXEC aborts without any write
        issue(16'h0312);
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("abort_async_clear", 64'(snap()), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort_hold%0d", k), 64'(snap()), 64'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_release_ready", 64'(snap()), 64'(model(16'h0, 0)));

        // Valid held high with three queued instructions
        q[0] = 16'h0352; q[1] = 16'h51F6; q[2] = 16'h0A13;
        idx = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (done) done_cyc.push_back(cyc);
            if (idx < 3) begin
                instr_valid = 1'b1;
                instr = q[idx];
                if (instr_ready) idx++;
            end else begin
                instr_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("burst_done_count", 64'(done_cyc.size()), 64'd3);
        if (done_cyc.size() == 3) begin
            chk("burst_gap1", 64'(done_cyc[1] - done_cyc[0]), PIPE ? 64'd3 : 64'd4);
            chk("burst_gap2", 64'(done_cyc[2] - done_cyc[1]), PIPE ? 64'd3 : 64'd4);
        end
        wait_ready();

        // Randomized instructions against the reference model
        for (int n = 0; n < 40; n++) begin
            w = 16'($urandom);
            case ($urandom_range(0, 7))
                0: w = 16'h0000;
                1: w[15:12] = 4'h0;
                2: begin w[15:12] = 4'h0; w[7:4] = 4'hB; end
                3: w[15:12] = 4'hB;
                default: ;
            endcase
            run_model(w);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
